// File: rtl/multicycle_control.sv
// Multicycle control FSM for the 16-bit TSC ISA: sequences IF/ID/EX/MEM/WB,
// drives datapath selects and counts retired instructions.
module multicycle_control (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] instr,
  input  logic        mem_ready,
  input  logic        branch_cond,
  output logic        i_mem_read,
  output logic        d_mem_read,
  output logic        d_mem_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  pc_src,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wb_src,
  output logic        ext_mode,
  output logic        alu_src_b,
  output logic [2:0]  state,
  output logic [15:0] num_inst,
  output logic        wwd_valid,
  output logic        is_halted
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  state_t      state_r, next_state_s;
  logic [15:0] num_inst_r;
  logic        retire_s;
  logic [3:0]  opcode_s;
  logic [5:0]  func_s;
  logic        is_branch_s, is_imm_s, is_lwd_s, is_swd_s, is_jmp_s, is_jal_s;
  logic        is_rtype_s, is_jpr_s, is_jrl_s, is_wwd_s, is_hlt_s, is_undef_s;
  logic        i_mem_read_s, d_mem_read_s, d_mem_write_s, ir_write_s;
  logic        pc_write_s, reg_write_s, wwd_valid_s, is_halted_s;
  logic [1:0]  pc_src_s, reg_dst_s, wb_src_s;

  assign opcode_s = instr[15:12];
  assign func_s   = instr[5:0];

  // Instruction class decode from the current IR contents
  always_comb begin
    is_branch_s = (opcode_s <= 4'd3);
    is_imm_s    = (opcode_s >= 4'd4) && (opcode_s <= 4'd6);
    is_lwd_s    = (opcode_s == 4'd7);
    is_swd_s    = (opcode_s == 4'd8);
    is_jmp_s    = (opcode_s == 4'd9);
    is_jal_s    = (opcode_s == 4'd10);
    is_rtype_s  = 1'b0;
    is_jpr_s    = 1'b0;
    is_jrl_s    = 1'b0;
    is_wwd_s    = 1'b0;
    is_hlt_s    = 1'b0;
    is_undef_s  = 1'b0;
    if (opcode_s == 4'd15) begin
      is_rtype_s = (func_s <= 6'd7);
      is_jpr_s   = (func_s == 6'd25);
      is_jrl_s   = (func_s == 6'd26);
      is_wwd_s   = (func_s == 6'd28);
      is_hlt_s   = (func_s == 6'd29);
      is_undef_s = !((func_s <= 6'd7) || (func_s == 6'd25) || (func_s == 6'd26) ||
                     (func_s == 6'd28) || (func_s == 6'd29));
    end else begin
      is_undef_s = (opcode_s >= 4'd11);
    end
  end

  // Next-state, retire and per-state control decode
  always_comb begin
    next_state_s  = state_r;
    retire_s      = 1'b0;
    i_mem_read_s  = 1'b0;
    d_mem_read_s  = 1'b0;
    d_mem_write_s = 1'b0;
    ir_write_s    = 1'b0;
    pc_write_s    = 1'b0;
    reg_write_s   = 1'b0;
    wwd_valid_s   = 1'b0;
    is_halted_s   = 1'b0;
    pc_src_s      = 2'd0;
    reg_dst_s     = 2'd0;
    wb_src_s      = 2'd0;
    case (state_r)
      S_IF: begin
        i_mem_read_s = 1'b1;
        if (mem_ready) begin
          ir_write_s   = 1'b1;
          next_state_s = S_ID;
        end else begin
          next_state_s = S_IF;
        end
      end
      S_ID: begin
        if (is_hlt_s) begin
          next_state_s = S_HALT;
        end else if (is_jmp_s) begin
          pc_write_s   = 1'b1;
          pc_src_s     = 2'd2;
          retire_s     = 1'b1;
          next_state_s = S_IF;
        end else if (is_undef_s) begin
          pc_write_s   = 1'b1;
          retire_s     = 1'b1;
          next_state_s = S_IF;
        end else begin
          next_state_s = S_EX;
        end
      end
      S_EX: begin
        if (is_lwd_s || is_swd_s) begin
          next_state_s = S_MEM;
        end else if (is_branch_s || is_wwd_s || is_jpr_s) begin
          pc_write_s   = 1'b1;
          pc_src_s     = is_jpr_s ? 2'd3 : ((is_branch_s && branch_cond) ? 2'd1 : 2'd0);
          wwd_valid_s  = is_wwd_s;
          retire_s     = 1'b1;
          next_state_s = S_IF;
        end else begin
          next_state_s = S_WB;
        end
      end
      S_MEM: begin
        d_mem_read_s  = is_lwd_s;
        d_mem_write_s = !is_lwd_s;
        if (!mem_ready) begin
          next_state_s = S_MEM;
        end else if (is_lwd_s) begin
          next_state_s = S_WB;
        end else begin
          pc_write_s   = 1'b1;
          retire_s     = 1'b1;
          next_state_s = S_IF;
        end
      end
      S_WB: begin
        reg_write_s  = 1'b1;
        pc_write_s   = 1'b1;
        retire_s     = 1'b1;
        next_state_s = S_IF;
        if (is_jal_s || is_jrl_s) begin
          reg_dst_s = 2'd2;
          wb_src_s  = 2'd2;
          pc_src_s  = is_jrl_s ? 2'd3 : 2'd2;
        end else if (is_lwd_s) begin
          wb_src_s = 2'd1;
        end else if (is_rtype_s) begin
          reg_dst_s = 2'd1;
        end else begin
          reg_dst_s = 2'd0;
        end
      end
      S_HALT: begin
        is_halted_s  = 1'b1;
        next_state_s = S_HALT;
      end
      default: begin
        next_state_s = S_IF;
      end
    endcase
  end

  // State register and retired-instruction counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= S_IF;
      num_inst_r <= 16'd0;
    end else begin
      state_r <= next_state_s;
      if (retire_s) begin
        num_inst_r <= num_inst_r + 16'd1;
      end else begin
        num_inst_r <= num_inst_r;
      end
    end
  end

  // Reset must silence the controls even though the state is already IF
  assign i_mem_read  = reset_n & i_mem_read_s;
  assign d_mem_read  = reset_n & d_mem_read_s;
  assign d_mem_write = reset_n & d_mem_write_s;
  assign ir_write    = reset_n & ir_write_s;
  assign pc_write    = reset_n & pc_write_s;
  assign reg_write   = reset_n & reg_write_s;
  assign wwd_valid   = reset_n & wwd_valid_s;
  assign is_halted   = reset_n & is_halted_s;
  assign pc_src      = reset_n ? pc_src_s  : 2'd0;
  assign reg_dst     = reset_n ? reg_dst_s : 2'd0;
  assign wb_src      = reset_n ? wb_src_s  : 2'd0;
  assign ext_mode    = is_jmp_s || is_jal_s;
  assign alu_src_b   = (opcode_s >= 4'd4) && (opcode_s <= 4'd8);
  assign state       = state_r;
  assign num_inst    = num_inst_r;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The module SHALL have no parameters; opcode = instr[15:12], func = instr[5:0], following the 16-bit TSC ISA.
REQ-002 clk  input  1  rising-edge system clock; the only clock.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 instr  input  16  current IR contents, valid from the cycle after the ir_write pulse.
REQ-005 mem_ready  input  1  one-cycle memory completion strobe for the outstanding request.
REQ-006 branch_cond  input  1  ALU branch comparison result, valid in EX.
REQ-007 i_mem_read  output  1  instruction-fetch request, level-held until mem_ready.
REQ-008 d_mem_read, d_mem_write  output  1 each  data-memory requests, level-held until mem_ready.
REQ-009 ir_write, pc_write, reg_write  output  1 each  single-cycle write enables.
REQ-010 pc_src  output  2  next-PC select: 0 = PC+1, 1 = branch target, 2 = jump target {PC[15:12], instr[11:0]}, 3 = register rs.
REQ-011 reg_dst  output  2  0 = rt instr[9:8], 1 = rd instr[7:6], 2 = $2 (link).
REQ-012 wb_src  output  2  0 = ALU, 1 = memory data, 2 = PC+1.
REQ-013 ext_mode  output  1  immediate extender select: 1 = 12-bit target field (opcode 9 or 10), 0 = 8-bit sign-extend.
REQ-014 alu_src_b  output  1  1 = extended immediate, 0 = rt register.
REQ-015 state  output  3  current state: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5.
REQ-016 num_inst  output  16  count of retired instructions.
REQ-017 wwd_valid  output  1  one-cycle pulse while a WWD retires.
REQ-018 is_halted  output  1  high in HALT.

Function
REQ-019 The state register and num_inst SHALL update only on the rising edge of clk; all other outputs SHALL be combinational from state, instr, mem_ready and branch_cond.
REQ-020 IF SHALL assert i_mem_read, stay in IF while mem_ready=0, and on mem_ready=1 assert ir_write and go to ID.
REQ-021 From ID: HLT (opcode 15, func 29) goes to HALT; JMP (opcode 9) asserts pc_write with pc_src=2 and retires to IF; an undefined opcode/func asserts pc_write with pc_src=0 and retires to IF; all others go to EX.
REQ-022 In EX: LWD (7) and SWD (8) go to MEM; branches (opcodes 0-3) assert pc_write with pc_src=1 if branch_cond=1, else pc_src=0, and retire to IF; WWD (15/28) asserts pc_write with pc_src=0 and wwd_valid, and retires to IF; JPR (15/25) asserts pc_write with pc_src=3 and retires to IF; all others go to WB.
REQ-023 In MEM, LWD SHALL assert d_mem_read and SWD SHALL assert d_mem_write until mem_ready; on mem_ready, LWD goes to WB, while SWD asserts pc_write with pc_src=0 and retires to IF.
REQ-024 WB SHALL assert reg_write and pc_write, then go to IF, with:
- R-type ALU: reg_dst=1, wb_src=0, pc_src=0
- ADI/ORI/LHI (4-6): reg_dst=0, wb_src=0, pc_src=0
- LWD: reg_dst=0, wb_src=1, pc_src=0
- JAL (10): reg_dst=2, wb_src=2, pc_src=2
- JRL (15/26): reg_dst=2, wb_src=2, pc_src=3
REQ-025 alu_src_b SHALL be 1 for opcodes 4-8 and 0 otherwise; ext_mode SHALL follow opcode in every state.
REQ-026 "Retire" SHALL mean the transition into IF from ID, EX, MEM or WB; each retire SHALL increment num_inst by 1 (wrapping 16'hFFFF -> 0). HLT SHALL NOT be counted.
REQ-027 mem_ready SHALL be ignored outside IF and MEM. At most one memory request SHALL be asserted in any cycle.
REQ-028 HALT SHALL be absorbing: all enables and requests held at 0, is_halted=1, num_inst frozen; only reset exits it.

Reset
REQ-029 reset_n=0 SHALL immediately force state=IF and num_inst=0, regardless of the current state or any outstanding memory wait; outstanding requests are abandoned.
REQ-030 While reset_n=0, every write enable, memory request, wwd_valid and is_halted SHALL be 0, and pc_src, reg_dst and wb_src SHALL be 0.
REQ-031 After reset_n rises, the first request SHALL be i_mem_read in IF on the next cycle.

Verification
REQ-032 ADI (0x4xxx) with mem_ready delayed 3 cycles -> IF held 3 cycles with i_mem_read=1; ir_write pulses once; reg_write, reg_dst=0 and wb_src=0 assert in WB; num_inst=1.
REQ-033 BEQ with branch_cond=1, then with branch_cond=0 -> pc_src=1 then 0 in EX; no reg_write; num_inst +2.
REQ-034 LWD then SWD, each with 2-cycle memory waits -> d_mem_read held until mem_ready then wb_src=1 in WB; d_mem_write held until mem_ready then retires to IF from MEM.
REQ-035 JAL 0xA123 -> ext_mode=1, retires via WB with pc_src=2, reg_dst=2, wb_src=2; WWD -> exactly one wwd_valid pulse.
REQ-036 HLT -> is_halted=1, state=5, and no further requests over 20 cycles; reset_n pulsed low mid-MEM of an LWD -> state=0 asynchronously, num_inst=0.
REQ-037 Feed 65536 single-instruction retirements -> num_inst wraps to 0.
